// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the CPU data-memory bus. It takes one load/store
// request at a time, waits a programmable number of cycles, then commits the
// access to an internal word-addressed RAM and presents the response until
// the CPU accepts it. Misaligned or out-of-range byte addresses produce an
// error response and never touch the RAM.
//
// Parameters:
//   DEPTH   - number of 32-bit words in the RAM (power of two, >= 2)
//   AW      - word-index width, log2(DEPTH)
//   LATENCY - wait cycles between acceptance and commit (0..15)
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   reset_n     - asynchronous active-low reset
//   req_valid   - CPU presents a request
//   req_ready   - responder is idle and can take a request
//   req_write   - 1 = store, 0 = load
//   req_addr    - byte address
//   req_wdata   - store data
//   resp_valid  - response available, held until resp_ready
//   resp_ready  - CPU takes the response
//   resp_rdata  - load data (0 for stores and errors)
//   resp_err    - misaligned or out-of-range access
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } stateT;

  // Storage and control state
  logic [31:0]   r_mem [DEPTH];
  stateT         r_state;
  logic [3:0]    r_count;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_reqReady;
  logic          r_respValid;
  logic [31:0]   r_respRdata;
  logic          r_respErr;

  // Command actually committed and its decode
  logic          w_accept;
  logic          w_commit;
  logic          w_cmdWrite;
  logic [31:0]   w_cmdAddr;
  logic [31:0]   w_cmdWdata;
  logic          w_addrErr;
  logic [AW-1:0] w_index;
  logic          w_memWrite;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // With zero latency the commit happens on the acceptance edge itself, so
  // the command comes straight from the request inputs; otherwise it comes
  // from the copy latched at acceptance. Gating with reset_n guarantees that
  // an edge seen while reset is held can never write the RAM.
  assign w_commit   = reset_n &&
                      ((LATENCY == 0) ? w_accept
                                      : ((r_state == S_WAIT) && (r_count == 4'd1)));
  assign w_cmdWrite = (LATENCY == 0) ? req_write : r_write;
  assign w_cmdAddr  = (LATENCY == 0) ? req_addr  : r_addr;
  assign w_cmdWdata = (LATENCY == 0) ? req_wdata : r_wdata;

  // Any address bit above the word index makes the access out of range;
  // there is no wrap-around.
  assign w_addrErr  = (w_cmdAddr[1:0] != 2'b00) ||
                      ((w_cmdAddr >> (AW + 2)) != 32'd0);
  assign w_index    = w_cmdAddr[AW+1:2];
  assign w_memWrite = w_commit && w_cmdWrite && !w_addrErr;

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_memWrite) begin
      r_mem[w_index] <= w_cmdWdata;
    end
  end

  // Request/response FSM with registered handshake outputs. The response
  // payload is captured only on the commit edge, which keeps it stable for
  // the whole time resp_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respRdata <= 32'd0;
      r_respErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_reqReady <= 1'b0;
            if (LATENCY == 0) begin
              r_state     <= S_RESP;
              r_respValid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_count <= 4'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          if (r_count == 4'd1) begin
            r_state     <= S_RESP;
            r_count     <= 4'd0;
            r_respValid <= 1'b1;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_RESP: begin
          // Leaving RESP returns to IDLE only; a request waiting on
          // req_valid is taken at the next edge, not this one.
          if (resp_ready) begin
            r_state     <= S_IDLE;
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_count     <= 4'd0;
          r_respValid <= 1'b0;
          r_reqReady  <= 1'b1;
        end
      endcase

      if (w_commit) begin
        r_respErr   <= w_addrErr;
        r_respRdata <= (w_addrErr || w_cmdWrite) ? 32'd0 : r_mem[w_index];
      end
    end
  end

  assign req_ready  = r_reqReady;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

endmodule
